// File: rtl/menu_overlay_render.sv
// Text-mode menu overlay renderer: fetches one scanline of glyph bytes from the
// menu RAM into a ping-pong line buffer and streams 1-bit overlay pixels from it.
module menu_overlay_render #(
   parameter int          COLS      = 32,
   parameter int          ROWS      = 28,
   parameter logic [10:0] FONT_BASE = 11'h400
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        line_start,
   input  logic [7:0]  fetch_y,
   input  logic        px_valid,
   input  logic [7:0]  px_x,
   output logic        mem_ce,
   output logic [10:0] mem_addr,
   input  logic [7:0]  mem_dout,
   output logic        ov_valid,
   output logic        ov_active,
   output logic        ov_pix,
   output logic        busy
);

   localparam int          CW       = $clog2(COLS);
   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_RD_CHR = 2'd1;
   localparam logic [1:0]  ST_RD_FNT = 2'd2;
   localparam logic [1:0]  ST_WR     = 2'd3;
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [8:0]  PX_LIM   = 9'(COLS * 8);
   localparam logic [8:0]  Y_LIM    = 9'(ROWS * 8);
   localparam logic [10:0] COLS_A   = 11'(COLS);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [4:0]    grow_q, grow_d;
   logic [2:0]    gline_q, gline_d;
   logic [7:0]    code_q, code_d;
   logic          disp_sel_q, disp_sel_d;
   logic [1:0]    vld_q, vld_d;
   logic          ov_valid_q, ov_valid_d;
   logic          ov_active_q, ov_active_d;
   logic          ov_pix_q, ov_pix_d;

   logic [7:0]    buf_q [2][COLS];
   logic          wr_en;
   logic [7:0]    wr_data;
   logic [10:0]   text_addr;
   logic [10:0]   font_addr;
   logic [7:0]    disp_byte;
   logic          in_range;

   assign text_addr = {6'b0, grow_q} * COLS_A + 11'(col_q);
   assign font_addr = FONT_BASE + {1'b0, mem_dout[6:0], 3'b000} + {8'b0, gline_q};

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      grow_d     = grow_q;
      gline_d    = gline_q;
      code_d     = code_q;
      disp_sel_d = disp_sel_q;
      vld_d      = vld_q;
      wr_en      = 1'b0;
      wr_data    = mem_dout ^ {8{code_q[7]}};
      mem_ce     = 1'b0;
      mem_addr   = 11'd0;
      case (state_q)
         ST_RD_CHR: begin
            mem_ce   = 1'b1;
            mem_addr = text_addr;
            state_d  = ST_RD_FNT;
         end
         ST_RD_FNT: begin
            mem_ce   = 1'b1;
            mem_addr = font_addr;
            code_d   = mem_dout;
            state_d  = ST_WR;
         end
         ST_WR: begin
            wr_en = 1'b1;
            if (col_q == LAST_COL) begin
               vld_d[~disp_sel_q] = 1'b1;
               state_d            = ST_IDLE;
            end else begin
               col_d   = col_q + 1'b1;
               state_d = ST_RD_CHR;
            end
         end
         default: ;
      endcase
      // A new line always wins: an in-flight fetch (even on its last WR) is
      // dropped and its buffer is shown as a blank line.
      if (line_start) begin
         wr_en             = 1'b0;
         disp_sel_d        = ~disp_sel_q;
         vld_d             = vld_q;
         vld_d[disp_sel_q] = 1'b0;
         grow_d            = fetch_y[7:3];
         gline_d           = fetch_y[2:0];
         col_d             = '0;
         state_d           = (enable && ({1'b0, fetch_y} < Y_LIM)) ? ST_RD_CHR : ST_IDLE;
      end
   end

   assign disp_byte = buf_q[disp_sel_q][px_x[3 +: CW]];
   assign in_range  = ({1'b0, px_x} < PX_LIM);

   always_comb begin
      ov_valid_d  = px_valid;
      ov_active_d = px_valid & vld_q[disp_sel_q] & in_range;
      ov_pix_d    = ov_active_d & disp_byte[px_x[2:0]];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         grow_q      <= '0;
         gline_q     <= '0;
         code_q      <= '0;
         disp_sel_q  <= 1'b0;
         vld_q       <= 2'b00;
         ov_valid_q  <= 1'b0;
         ov_active_q <= 1'b0;
         ov_pix_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         grow_q      <= grow_d;
         gline_q     <= gline_d;
         code_q      <= code_d;
         disp_sel_q  <= disp_sel_d;
         vld_q       <= vld_d;
         ov_valid_q  <= ov_valid_d;
         ov_active_q <= ov_active_d;
         ov_pix_q    <= ov_pix_d;
      end
   end

   // Line storage is gated by the valid flags, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) buf_q[~disp_sel_q][col_q] <= wr_data;
   end

   assign ov_valid  = ov_valid_q;
   assign ov_active = ov_active_q;
   assign ov_pix    = ov_pix_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_menu_overlay_render.sv
// Directed bench for menu_overlay_render with a behavioural 2 KB RAM; a second
// instance with COLS=20 covers the right-edge clip.
module tb_menu_overlay_render;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b1;
   logic        line_start = 1'b0;
   logic [7:0]  fetch_y = 8'd0;
   logic        px_valid = 1'b0;
   logic [7:0]  px_x = 8'd0;

   logic        mem_ce, ov_valid, ov_active, ov_pix, busy;
   logic [10:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        m20_ce, o20_valid, o20_active, o20_pix, busy20;
   logic [10:0] m20_addr;
   logic [7:0]  m20_dout;

   logic [7:0]  ram [2048];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   menu_overlay_render dut (
      .clk(clk), .resetn(resetn), .enable(enable), .line_start(line_start),
      .fetch_y(fetch_y), .px_valid(px_valid), .px_x(px_x),
      .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .ov_valid(ov_valid), .ov_active(ov_active), .ov_pix(ov_pix), .busy(busy)
   );

   menu_overlay_render #(.COLS(20)) dut20 (
      .clk(clk), .resetn(resetn), .enable(enable), .line_start(line_start),
      .fetch_y(fetch_y), .px_valid(px_valid), .px_x(px_x),
      .mem_ce(m20_ce), .mem_addr(m20_addr), .mem_dout(m20_dout),
      .ov_valid(o20_valid), .ov_active(o20_active), .ov_pix(o20_pix), .busy(busy20)
   );

   always @(posedge clk) begin
      if (mem_ce) mem_dout <= ram[mem_addr];
      if (m20_ce) m20_dout <= ram[m20_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic [7:0] y);
      @(negedge clk);
      line_start = 1'b1;
      fetch_y    = y;
      @(negedge clk);
      line_start = 1'b0;
   endtask

   // Pulse line_start, then count busy cycles and capture the first two addresses.
   task automatic do_fetch(input logic [7:0] y, output int cnt, output logic [10:0] a0,
                           output logic [10:0] a1, output logic anyce);
      pulse(y);
      cnt = 0; anyce = 1'b0; a0 = '0; a1 = '0;
      for (int i = 0; i < 200; i++) begin
         if (i == 0) a0 = mem_addr;
         if (i == 1) a1 = mem_addr;
         anyce = anyce | mem_ce;
         if (!busy) break;
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic px(input logic [7:0] x);
      @(negedge clk);
      px_valid = 1'b1;
      px_x     = x;
      @(negedge clk);
      px_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          cnt;
      logic [10:0] a0, a1;
      logic        anyce;
      logic [7:0]  inv;

      for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
      ram[11'h000] = 8'h41;
      ram[11'h001] = 8'h42;
      ram[11'h01F] = 8'h43;
      ram[11'h1A0] = 8'h41;
      ram[11'h608] = 8'h0C;
      ram[11'h60B] = 8'h5A;
      ram[11'h610] = 8'h81;
      ram[11'h618] = 8'h80;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ce", mem_ce, 0);
      check("rst_valid", ov_valid, 0);
      @(negedge clk) resetn = 1'b1;

      // Asynchronous reset in the middle of a fetch
      pulse(8'd0);
      px_valid = 1'b1;
      repeat (40) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_ovvalid", ov_valid, 1);
      #2 resetn = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_ce", mem_ce, 0);
      check("arst_addr", mem_addr, 0);
      check("arst_ovvalid", ov_valid, 0);
      check("arst_ovactive", ov_active, 0);
      check("arst_ovpix", ov_pix, 0);
      px_valid = 1'b0;
      @(negedge clk) resetn = 1'b1;

      px(8'd2);
      check("noline_valid", ov_valid, 1);
      check("noline_active", ov_active, 0);

      // Basic fetch of line 0
      do_fetch(8'd0, cnt, a0, a1, anyce);
      check("l0_busy_cycles", cnt, 96);
      check("l0_first_ce", anyce, 1);
      check("l0_text_addr", a0, 11'h000);
      check("l0_font_addr", a1, 11'h608);
      do_fetch(8'd224, cnt, a0, a1, anyce);
      check("y224_busy", cnt, 0);
      check("y224_no_ce", anyce, 0);
      for (int i = 0; i < 8; i++) begin
         px(8'(i));
         check("l0_active", ov_active, 1);
         check("l0_pix", ov_pix, (i == 2 || i == 3) ? 1 : 0);
      end
      px(8'd8);   check("l0_pix8", ov_pix, 1);
      px(8'd9);   check("l0_pix9", ov_pix, 0);
      px(8'd255); check("l0_pix255", ov_pix, 1);
      check("l0_active255", ov_active, 1);
      px(8'd254); check("l0_pix254", ov_pix, 0);

      // Narrow instance: column 160 lies past the 20-column overlay
      px(8'd159); check("c20_active159", o20_active, 1);
      px(8'd160); check("c20_active160", o20_active, 0);
      check("c20_pix160", o20_pix, 0);
      check("c20_valid160", o20_valid, 1);
      px(8'd2);   check("c20_pix2", o20_pix, 1);

      // Row 13 / glyph row 3 addressing; the out-of-range line is now shown
      do_fetch(8'h6B, cnt, a0, a1, anyce);
      check("r13_text_addr", a0, 11'h1A0);
      check("r13_font_addr", a1, 11'h60B);
      check("r13_busy_cycles", cnt, 96);
      px(8'd2);   check("y224_line_active", ov_active, 0);
      check("y224_line_pix", ov_pix, 0);

      // Disabled fetch; row 13 line is displayed meanwhile
      enable = 1'b0;
      do_fetch(8'd0, cnt, a0, a1, anyce);
      check("dis_busy", cnt, 0);
      check("dis_no_ce", anyce, 0);
      px(8'd0);   check("r13_pix0", ov_pix, 0);
      check("r13_active", ov_active, 1);
      px(8'd1);   check("r13_pix1", ov_pix, 1);
      px(8'd3);   check("r13_pix3", ov_pix, 1);
      px(8'd5);   check("r13_pix5", ov_pix, 0);
      enable = 1'b1;
      do_fetch(8'd224, cnt, a0, a1, anyce);
      px(8'd1);   check("dis_line_active", ov_active, 0);

      // Inverse video
      ram[11'h000] = 8'hC1;
      do_fetch(8'd0, cnt, a0, a1, anyce);
      check("inv_busy_cycles", cnt, 96);
      do_fetch(8'd224, cnt, a0, a1, anyce);
      inv = 8'b1111_0011;
      for (int i = 0; i < 8; i++) begin
         px(8'(i));
         check("inv_pix", ov_pix, inv[i]);
      end
      px(8'd8);   check("inv_next_cell", ov_pix, 1);

      // Abort: second line_start 40 cycles into a fetch
      pulse(8'd0);
      repeat (38) @(negedge clk);
      check("abort_midfetch_busy", busy, 1);
      do_fetch(8'd0, cnt, a0, a1, anyce);
      check("abort_new_busy_cycles", cnt, 96);
      px(8'd0);   check("abort_blank_active", ov_active, 0);
      check("abort_blank_pix", ov_pix, 0);
      do_fetch(8'd224, cnt, a0, a1, anyce);
      px(8'd0);   check("abort_new_active", ov_active, 1);
      check("abort_new_pix", ov_pix, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/menu_overlay_render.md
Name: menu_overlay_render

Overview:
- Read-side consumer of the 2 KB menu dual-port RAM; drives the RAM's read port.
- RAM map: text buffer at 0x000–0x37F, 32 cols x 28 rows, one byte per cell. 8x8 font at FONT_BASE + code*8 + glyph_row.
- Once per scanline, fetches one line of glyph bytes into a ping-pong line buffer during blanking.
- During active video, outputs a 1-bit overlay pixel stream that the video mixer composites over the Game Boy image.

Parameters:
- COLS, 32, text columns per row (8 px each, 256 px overlay width)
- ROWS, 28, text rows (224 px overlay height)
- FONT_BASE, 11'h400, byte address of glyph for code 0

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  overlay on; sampled only at line_start
- line_start  in  1  one-cycle pulse; swaps buffers and starts fetch of fetch_y
- fetch_y  in  8  overlay line to fetch for display after the next line_start
- px_valid  in  1  pixel request strobe
- px_x  in  8  pixel column within overlay, 0..255
- mem_ce  out  1  RAM read enable
- mem_addr  out  11  RAM read address
- mem_dout  in  8  RAM read data, valid exactly 1 cycle after mem_ce
- ov_valid  out  1  registered echo of px_valid
- ov_active  out  1  overlay covers this pixel
- ov_pix  out  1  foreground bit (meaningful only when ov_active)
- busy  out  1  fetch in progress

Behaviour:
- Reset: ov_valid, ov_active, ov_pix, mem_ce, busy = 0; mem_addr = 0; FSM = IDLE; both buffer valid flags = 0.
- Storage: two buffers A/B, each COLS bytes plus a valid flag. disp_sel selects the display buffer; the other is the fill buffer.

Line_start:
- Toggle disp_sel.
- Clear the new fill buffer's valid flag.
- Latch grow = fetch_y>>3 and gline = fetch_y[2:0].
- If enable=1 and fetch_y < ROWS*8: enter RD_CHR with col=0. Otherwise go to IDLE (fill buffer stays invalid).
- If line_start arrives mid-fetch, abort the old fetch. Its buffer becomes the display buffer with valid=0 (blank line), and the new fetch starts in the same cycle.

FSM:
- IDLE: mem_ce=0, busy=0.
- RD_CHR: mem_ce=1, mem_addr = grow*COLS + col. Next state RD_FNT.
- RD_FNT: code = mem_dout. mem_ce=1, mem_addr = FONT_BASE + {code[6:0],3'b000} + gline. Next state WR.
- WR: fill[col] = mem_dout, inverted when the latched code[7]=1 (inverse video). mem_ce=0.
  - If col = COLS-1: set fill valid and go to IDLE.
  - Otherwise col++ and go to RD_CHR.
- Timing: exactly 3*COLS = 96 cycles from line_start to fill valid. busy=1 through the final WR cycle.

Pixel path:
- 1-cycle registered latency.
- ov_valid(t+1) = px_valid(t).
- ov_active(t+1) = px_valid & disp_valid & (px_x < COLS*8).
- ov_pix(t+1) = disp[px_x>>3][px_x[2:0]]. Bit 0 is the leftmost pixel.
- When ov_active=0, ov_pix is forced to 0.
- Pixel reads of the display buffer never conflict with fetch writes to the fill buffer.

Address arithmetic: all 11-bit and unsigned. Text addresses are never ≥ 0x380; font addresses fall in 0x400–0x7FF.

Test Plan:
- Reset: resetn low mid-fetch → all outputs 0 asynchronously. After release, px_valid with no line_start → ov_active=0.
- Basic fetch: text[0x000]=0x41, FONT 'A' row0=0x0C. Pulse line_start with fetch_y=0, then pulse again. px_x=0..7 → ov_pix = 0,0,1,1,0,0,0,0. busy high for exactly 96 cycles.
- Addressing: fetch_y=0x6B (row 13, gline 3) → first mem_addr = 0x1A0. Code 0x41 → font addr 0x60B.
- Inverse video: text byte 0xC1 on line 0 → pixels 0..7 = 1,1,0,0,1,1,1,1.
- Out-of-range or disabled: fetch_y=224, or enable=0 → no mem_ce, ov_active=0 for that line. px_x ≥ 256 is not representable, so also check COLS=20 → px_x=160 gives ov_active=0.
- Abort: second line_start 40 cycles into a fetch → displayed line blank (ov_active=0), new fetch completes 96 cycles after the second pulse.
